dac_wave_gen: RTL and testbench



---
 rtl/dac_wave_gen_if.sv | 11 +
 rtl/dac_wave_gen.sv | 178 +++++++++++++++++
 tb/tb_dac_wave_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_wave_gen_if.sv
// Start/data/done handshake between the waveform sequencer and the SPI DAC master.
interface dac_wave_gen_if #(
    parameter int unsigned DATA_W = 12
) ();
    logic              dac_start;
    logic [DATA_W-1:0] dac_data;
    logic              dac_done;

    modport master (output dac_start, output dac_data, input dac_done);
    modport slave  (input dac_start, input dac_data, output dac_done);
endinterface

// File: rtl/dac_wave_gen.sv
// Paced waveform sequencer: emits one DAC code per period (saw up/down, triangle, hold)
// and flags overrun when the SPI frame outlives the period.
module dac_wave_gen #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   lo,
    input  logic [DATA_W-1:0]   hi,
    input  logic [DATA_W-1:0]   step,
    input  logic [PERIOD_W-1:0] period,
    dac_wave_gen_if.master      dac,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned EXT_W = DATA_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_PACE  = 2'd3;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_TRI  = 2'b10;

    logic [1:0]          state, state_nxt;
    logic [DATA_W-1:0]   cur, cur_nxt;
    logic                dir_down, dir_nxt;
    logic [PERIOD_W-1:0] timer, timer_nxt;
    logic                start_q, start_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic                busy_nxt;
    logic                ovr_nxt;
    logic                ovr_seen, ovr_seen_nxt;

    logic [DATA_W-1:0]   code_next_c;
    logic                dir_next_c;
    logic [DATA_W-1:0]   start_code_c;
    logic [PERIOD_W-1:0] timer_dec_c;
    logic [PERIOD_W-1:0] timer_load_c;

    logic [EXT_W-1:0]    cur_w, lo_w, hi_w, step_w, up_w, lo_step_w;

    // Next code from the current one; widened so sums never wrap.
    always_comb begin
        cur_w       = EXT_W'(cur);
        lo_w        = EXT_W'(lo);
        hi_w        = EXT_W'(hi);
        step_w      = EXT_W'(step);
        up_w        = cur_w + step_w;
        lo_step_w   = lo_w + step_w;
        code_next_c = cur;
        dir_next_c  = dir_down;
        if (lo >= hi) begin
            code_next_c = lo;
        end else begin
            case (mode)
                M_UP:   code_next_c = (up_w > hi_w) ? lo : DATA_W'(up_w);
                M_DOWN: code_next_c = (cur_w < lo_step_w) ? hi : cur - step;
                M_TRI: begin
                    if (!dir_down) begin
                        if (up_w >= hi_w) begin
                            code_next_c = hi;
                            dir_next_c  = 1'b1;
                        end else begin
                            code_next_c = DATA_W'(up_w);
                        end
                    end else begin
                        if (cur_w <= lo_step_w) begin
                            code_next_c = lo;
                            dir_next_c  = 1'b0;
                        end else begin
                            code_next_c = cur - step;
                        end
                    end
                end
                default: code_next_c = lo;
            endcase
        end
    end

    assign start_code_c = ((lo >= hi) || (mode != M_DOWN)) ? lo : hi;
    assign timer_dec_c  = (timer == '0) ? '0 : timer - PERIOD_W'(1);
    assign timer_load_c = (period == '0) ? '0 : period - PERIOD_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        dir_nxt      = dir_down;
        timer_nxt    = timer;
        start_nxt    = 1'b0;
        data_nxt     = data_q;
        busy_nxt     = busy;
        ovr_nxt      = 1'b0;
        ovr_seen_nxt = ovr_seen;
        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (enable) begin
                    cur_nxt   = start_code_c;
                    dir_nxt   = 1'b0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_nxt    = 1'b1;
                data_nxt     = cur;
                timer_nxt    = timer_load_c;
                busy_nxt     = 1'b1;
                cur_nxt      = code_next_c;
                dir_nxt      = dir_next_c;
                ovr_seen_nxt = 1'b0;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                timer_nxt = timer_dec_c;
                if (dac.dac_done) begin
                    if (!enable) begin
                        busy_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end else if (timer == '0) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_PACE;
                    end
                end else if ((timer == '0) && !ovr_seen) begin
                    // Period expired with the frame still in flight; report once per sample.
                    ovr_nxt      = 1'b1;
                    ovr_seen_nxt = 1'b1;
                end
            end
            S_PACE: begin
                timer_nxt = timer_dec_c;
                if (!enable) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else if (timer == '0) begin
                    state_nxt = S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cur      <= '0;
            dir_down <= 1'b0;
            timer    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            ovr_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            dir_down <= dir_nxt;
            timer    <= timer_nxt;
            start_q  <= start_nxt;
            data_q   <= data_nxt;
            busy     <= busy_nxt;
            overrun  <= ovr_nxt;
            ovr_seen <= ovr_seen_nxt;
        end
    end

    assign dac.dac_start = start_q;
    assign dac.dac_data  = data_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Scoreboard bench for dac_wave_gen: reference sequence model, SPI reply model, monitor.
module tb_dac_wave_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] lo, hi, step;
    logic [15:0] period;
    logic        busy;
    logic        overrun;

    dac_wave_gen_if #(.DATA_W(12)) bus ();

    dac_wave_gen #(.DATA_W(12), .PERIOD_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .step    (step),
        .period  (period),
        .dac     (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        bit first;
        int gap;
        int ovr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat    = 10;
    int   start_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // SPI master model: one-cycle dac_done 'lat' cycles after each dac_start.
    initial begin
        bus.dac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.dac_start) begin
                repeat (lat) @(negedge clk);
                bus.dac_done = 1'b1;
                @(negedge clk);
                bus.dac_done = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per dac_start and checks code, spacing and overruns.
    initial begin
        int   cyc = 0;
        int   last_cyc = 0;
        int   ov_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_cnt = 0;
            end else begin
                cyc++;
                if (overrun) ov_cnt++;
                if (bus.dac_start) begin
                    start_cnt++;
                    if (q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("dac_data", int'(bus.dac_data), e.code);
                        check("busy_at_start", int'(busy), 1);
                        if (!e.first) begin
                            check("start_spacing", cyc - last_cyc, e.gap);
                            check("overrun_count", ov_cnt, e.ovr);
                        end
                    end
                    last_cyc = cyc;
                    ov_cnt   = 0;
                end
            end
        end
    end

    // Reference: expected code sequence, spacing and overruns from the waveform rules.
    task automatic push_run(input int m, input int l, input int h, input int s,
                            input int p, input int lt, input int n, output int gap);
        int  pe;
        int  ov;
        int  c;
        bit  down;
        exp_t e;
        pe   = (p == 0) ? 1 : p;
        gap  = ((pe > lt) ? pe : lt + 1) + 1;
        ov   = (pe <= lt) ? 1 : 0;
        c    = (l >= h) ? l : ((m == 1) ? h : l);
        down = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.code  = c;
            e.first = (i == 0);
            e.gap   = gap;
            e.ovr   = ov;
            q.push_back(e);
            if (l >= h) begin
                c = l;
            end else begin
                case (m)
                    0: c = (c + s > h) ? l : c + s;
                    1: c = (c < l + s) ? h : c - s;
                    2: begin
                        if (!down) begin
                            if (c + s >= h) begin c = h; down = 1'b1; end
                            else c = c + s;
                        end else begin
                            if (c - s <= l) begin c = l; down = 1'b0; end
                            else c = c - s;
                        end
                    end
                    default: c = l;
                endcase
            end
        end
    endtask

    task automatic do_run(input int m, input int l, input int h, input int s,
                          input int p, input int lt, input int n);
        int gap;
        int budget;
        int k;
        @(negedge clk);
        mode   = 2'(m);
        lo     = 12'(l);
        hi     = 12'(h);
        step   = 12'(s);
        period = 16'(p);
        lat    = lt;
        push_run(m, l, h, s, p, lt, n, gap);
        enable = 1'b1;
        budget = n * (gap + 4) + 20;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        if (q.size() != 0) begin
            check("run_timeout", q.size(), 0);
            q.delete();
        end
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("busy_after_disable", int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int sc;
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'b00;
        lo     = '0;
        hi     = '0;
        step   = '0;
        period = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dac_start", int'(bus.dac_start), 0);
        check("rst_dac_data", int'(bus.dac_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_no_start", start_cnt, 0);
        check("idle_busy", int'(busy), 0);

        do_run(0, 0, 4095, 1024, 40, 35, 7);
        do_run(2, 100, 400, 150, 40, 35, 7);
        do_run(1, 10, 50, 30, 20, 12, 6);
        do_run(0, 0, 4095, 1024, 10, 35, 5);
        do_run(3, 200, 900, 77, 0, 1, 5);
        do_run(2, 300, 300, 40, 5, 4, 5);
        do_run(1, 800, 100, 40, 6, 5, 4);
        do_run(0, 17, 3000, 0, 3, 2, 4);
        do_run(2, 0, 4095, 4095, 2, 6, 5);

        for (int r = 0; r < 12; r++) begin
            do_run($urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 4095),
                   $urandom_range(0, 1500), $urandom_range(0, 50), $urandom_range(1, 50),
                   $urandom_range(3, 7));
        end

        // Reset asserted while a frame is in flight.
        @(negedge clk);
        mode = 2'b00; lo = 12'd5; hi = 12'd100; step = 12'd1; period = 16'd30; lat = 20;
        begin
            int g;
            push_run(0, 5, 100, 1, 30, 20, 1, g);
        end
        enable = 1'b1;
        sc = 0;
        while (q.size() != 0 && sc < 50) begin
            @(negedge clk);
            sc++;
        end
        check("midframe_first_start", q.size(), 0);
        q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_dac_start", int'(bus.dac_start), 0);
        check("midrst_dac_data", int'(bus.dac_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overrun", int'(overrun), 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sc = start_cnt;
        repeat (40) @(negedge clk);
        check("post_rst_no_start", start_cnt - sc, 0);
        check("post_rst_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
